// File: rtl/mem_wb_pkg.sv
// rtl/mem_wb_pkg.sv - shared widths and load-mask bit positions for the MEM/WB slice
package mem_wb_pkg;

  localparam int XLEN          = 32;
  localparam int RF_ADDR_WIDTH = 5;
  localparam int LMASK_WIDTH   = 5;

  localparam logic [XLEN-1:0] ZEROWORD = '0;

  localparam int LMASK_LB  = 0;
  localparam int LMASK_LH  = 1;
  localparam int LMASK_LW  = 2;
  localparam int LMASK_LBU = 3;
  localparam int LMASK_LHU = 4;

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - selects and extends the byte/half/word of a loaded word
module load_align
  import mem_wb_pkg::*;
(
  input  logic [XLEN-1:0]        i_word,
  input  logic [1:0]             i_addr_2low,
  input  logic [LMASK_WIDTH-1:0] i_l_mask,
  output logic [XLEN-1:0]        o_aligned
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_word[{i_addr_2low, 3'b000} +: 8];
  // Halfword loads are assumed aligned, so only addr bit 1 picks the half.
  assign w_half = i_addr_2low[1] ? i_word[16 +: 16] : i_word[0 +: 16];

  always_comb begin
    o_aligned = i_word;
    if (i_l_mask[LMASK_LB])
      o_aligned = {{(XLEN-8){w_byte[7]}}, w_byte};
    else if (i_l_mask[LMASK_LH])
      o_aligned = {{(XLEN-16){w_half[15]}}, w_half};
    else if (i_l_mask[LMASK_LBU])
      o_aligned = {{(XLEN-8){1'b0}}, w_byte};
    else if (i_l_mask[LMASK_LHU])
      o_aligned = {{(XLEN-16){1'b0}}, w_half};
    else if (i_l_mask[LMASK_LW])
      o_aligned = i_word;
    else
      o_aligned = i_word | ZEROWORD;
  end

endmodule

// File: rtl/mem_wb.sv
// rtl/mem_wb.sv - MEM stage load-wait control and MEM/WB pipeline register
module mem_wb #(
  parameter int XLEN          = mem_wb_pkg::XLEN,
  parameter int RF_ADDR_WIDTH = mem_wb_pkg::RF_ADDR_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ex_mem_valid,
  input  logic                     wb_allowin,
  output logic                     mem_allowin,
  output logic                     mem_valid,
  output logic                     mem_wb_valid,
  input  logic [XLEN-1:0]          mem_pc,
  input  logic [XLEN-1:0]          mem_inst,
  input  logic                     mem_req_rf,
  input  logic [RF_ADDR_WIDTH-1:0] mem_rf_waddr,
  input  logic [XLEN-1:0]          mem_alu_res,
  input  logic                     mem_is_load,
  input  logic [1:0]               mem_ls_addr_2low,
  input  logic [4:0]               mem_l_mask,
  input  logic [XLEN-1:0]          dmem_rdata,
  input  logic                     dmem_rvalid,
  output logic                     wb_valid,
  output logic [XLEN-1:0]          wb_pc,
  output logic [XLEN-1:0]          wb_inst,
  output logic                     wb_req_rf,
  output logic [RF_ADDR_WIDTH-1:0] wb_rf_waddr,
  output logic [XLEN-1:0]          wb_wdata
);

  import mem_wb_pkg::*;

  logic                     r_mem_valid;
  logic                     r_rdata_hold;
  logic [XLEN-1:0]          r_rdata_buf;
  logic                     r_wb_valid;
  logic [XLEN-1:0]          r_wb_pc;
  logic [XLEN-1:0]          r_wb_inst;
  logic                     r_wb_req_rf;
  logic [RF_ADDR_WIDTH-1:0] r_wb_rf_waddr;
  logic [XLEN-1:0]          r_wb_wdata;

  logic            w_ready_go;
  logic            w_wb_xfer;
  logic            w_buf_capture;
  logic [XLEN-1:0] w_load_word;
  logic [XLEN-1:0] w_aligned;
  logic [XLEN-1:0] w_wdata;

  assign w_ready_go   = !mem_is_load || dmem_rvalid || r_rdata_hold;
  assign mem_allowin  = !r_mem_valid || (w_ready_go && wb_allowin);
  assign mem_wb_valid = r_mem_valid && w_ready_go;
  assign w_wb_xfer    = mem_wb_valid && wb_allowin;

  // A response that WB cannot take now is parked so memory never has to resend it.
  assign w_buf_capture = r_mem_valid && mem_is_load && dmem_rvalid
                         && !r_rdata_hold && !wb_allowin;

  assign w_load_word = r_rdata_hold ? r_rdata_buf : dmem_rdata;
  assign w_wdata     = mem_is_load ? w_aligned : mem_alu_res;

  load_align u_load_align (
    .i_word      (w_load_word),
    .i_addr_2low (mem_ls_addr_2low),
    .i_l_mask    (mem_l_mask),
    .o_aligned   (w_aligned)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mem_valid   <= 1'b0;
      r_rdata_hold  <= 1'b0;
      r_rdata_buf   <= '0;
      r_wb_valid    <= 1'b0;
      r_wb_pc       <= '0;
      r_wb_inst     <= '0;
      r_wb_req_rf   <= 1'b0;
      r_wb_rf_waddr <= '0;
      r_wb_wdata    <= '0;
    end else begin
      if (mem_allowin)
        r_mem_valid <= ex_mem_valid;

      if (w_wb_xfer) begin
        r_rdata_hold <= 1'b0;
      end else if (w_buf_capture) begin
        r_rdata_hold <= 1'b1;
        r_rdata_buf  <= dmem_rdata;
      end

      if (wb_allowin)
        r_wb_valid <= mem_wb_valid;

      if (w_wb_xfer) begin
        r_wb_pc       <= mem_pc;
        r_wb_inst     <= mem_inst;
        r_wb_req_rf   <= mem_req_rf;
        r_wb_rf_waddr <= mem_rf_waddr;
        r_wb_wdata    <= w_wdata;
      end
    end
  end

  assign mem_valid   = r_mem_valid;
  assign wb_valid    = r_wb_valid;
  assign wb_pc       = r_wb_pc;
  assign wb_inst     = r_wb_inst;
  assign wb_req_rf   = r_wb_req_rf;
  assign wb_rf_waddr = r_wb_rf_waddr;
  assign wb_wdata    = r_wb_wdata;

endmodule

// File: tb/tb_mem_wb.sv
// tb/tb_mem_wb.sv - randomized bench for mem_wb against a slot-level reference model
module tb_mem_wb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_mem_valid, wb_allowin, mem_allowin, mem_valid, mem_wb_valid;
  logic [31:0] mem_pc, mem_inst, mem_alu_res, dmem_rdata;
  logic        mem_req_rf, mem_is_load, dmem_rvalid;
  logic [4:0]  mem_rf_waddr, mem_l_mask;
  logic [1:0]  mem_ls_addr_2low;
  logic        wb_valid, wb_req_rf;
  logic [31:0] wb_pc, wb_inst, wb_wdata;
  logic [4:0]  wb_rf_waddr;

  always #5 clk = ~clk;

  mem_wb dut (
    .clk(clk), .rst_n(rst_n), .ex_mem_valid(ex_mem_valid), .wb_allowin(wb_allowin),
    .mem_allowin(mem_allowin), .mem_valid(mem_valid), .mem_wb_valid(mem_wb_valid),
    .mem_pc(mem_pc), .mem_inst(mem_inst), .mem_req_rf(mem_req_rf),
    .mem_rf_waddr(mem_rf_waddr), .mem_alu_res(mem_alu_res), .mem_is_load(mem_is_load),
    .mem_ls_addr_2low(mem_ls_addr_2low), .mem_l_mask(mem_l_mask),
    .dmem_rdata(dmem_rdata), .dmem_rvalid(dmem_rvalid), .wb_valid(wb_valid),
    .wb_pc(wb_pc), .wb_inst(wb_inst), .wb_req_rf(wb_req_rf),
    .wb_rf_waddr(wb_rf_waddr), .wb_wdata(wb_wdata)
  );

  typedef struct {
    logic [31:0] pc, inst, alu, rdata, exp;
    logic        req_rf, is_load, chk_en;
    logic [4:0]  waddr, mask;
    logic [1:0]  a2;
    int          delay, wstall, tag;
  } instr_t;

  instr_t cur, nxt;
  instr_t dir_q[$];

  // reference model: one MEM slot plus the WB record
  logic        m_valid, m_have;
  logic [31:0] m_data;
  logic        e_wb_valid, e_req;
  logic [31:0] e_pc, e_inst, e_wdata;
  logic [4:0]  e_waddr;

  logic        resp_sent, hold_ex, pend_chk;
  logic [31:0] pend_exp;
  int          wait_cnt, stall_cnt;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] align_ref(logic [31:0] w, logic [1:0] a, logic [4:0] m);
    int b, h;
    b = int'((w >> (8 * a)) & 32'hFF);
    h = int'((w >> (16 * a[1])) & 32'hFFFF);
    case (m)
      5'b00001: return 32'(b - ((b >= 128) ? 256 : 0));
      5'b00010: return 32'(h - ((h >= 32768) ? 65536 : 0));
      5'b01000: return 32'(b);
      5'b10000: return 32'(h);
      default:  return w;
    endcase
  endfunction

  function automatic instr_t rand_instr();
    instr_t t;
    int k;
    t.pc = $urandom; t.inst = $urandom; t.alu = $urandom; t.rdata = $urandom;
    t.req_rf = 1'($urandom); t.waddr = 5'($urandom); t.a2 = 2'($urandom);
    t.is_load = ($urandom % 2) == 0;
    k = $urandom % 6;
    t.mask = (k < 5) ? 5'(1 << k) : 5'd0;
    t.delay = $urandom % 5; t.wstall = 0; t.tag = 0; t.chk_en = 1'b0; t.exp = '0;
    return t;
  endfunction

  function automatic instr_t mk(logic ld, logic [31:0] alu, logic [1:0] a2, logic [4:0] mask,
                                logic [31:0] rd, int dly, int ws, logic [31:0] exp);
    instr_t t;
    t = rand_instr();
    t.is_load = ld; t.alu = alu; t.a2 = a2; t.mask = mask; t.rdata = rd;
    t.delay = dly; t.wstall = ws; t.exp = exp; t.chk_en = 1'b1;
    t.req_rf = 1'b1; t.waddr = 5'd5;
    return t;
  endfunction

  task automatic drive_inputs();
    mem_pc = cur.pc; mem_inst = cur.inst; mem_req_rf = cur.req_rf; mem_rf_waddr = cur.waddr;
    mem_alu_res = cur.alu; mem_is_load = cur.is_load; mem_ls_addr_2low = cur.a2;
    mem_l_mask = cur.mask;
    ex_mem_valid = hold_ex ? 1'b0 : (($urandom % 4) != 0);
    if (m_valid && cur.is_load && !resp_sent) begin
      if (wait_cnt == 0) begin
        dmem_rvalid = 1'b1; dmem_rdata = cur.rdata; resp_sent = 1'b1;
        stall_cnt = cur.wstall;
      end else begin
        wait_cnt--; dmem_rvalid = 1'b0; dmem_rdata = $urandom;
      end
    end else begin
      // stray pulses: must be ignored by the design in every state reaching here
      dmem_rvalid = (stall_cnt > 0) || (($urandom % 6) == 0);
      dmem_rdata = $urandom;
    end
    if (stall_cnt > 0) begin
      wb_allowin = 1'b0; stall_cnt--;
    end else begin
      wb_allowin = ($urandom % 4) != 0;
    end
  endtask

  task automatic tick();
    logic avail, offer, acc, take;
    logic [31:0] data;
    logic n_valid, n_have, n_wbv, rst_now, new_in;
    logic [31:0] n_data;
    @(negedge clk);
    avail = !cur.is_load || m_have || dmem_rvalid;
    offer = m_valid && avail;
    acc   = offer && wb_allowin;
    take  = !m_valid || acc;
    data  = m_have ? m_data : dmem_rdata;
    check("mem_valid", 32'(mem_valid), 32'(m_valid));
    check("mem_allowin", 32'(mem_allowin), 32'(take));
    check("mem_wb_valid", 32'(mem_wb_valid), 32'(offer));
    check("wb_valid", 32'(wb_valid), 32'(e_wb_valid));
    check("wb_pc", wb_pc, e_pc);
    check("wb_inst", wb_inst, e_inst);
    check("wb_req_rf", 32'(wb_req_rf), 32'(e_req));
    check("wb_rf_waddr", 32'(wb_rf_waddr), 32'(e_waddr));
    check("wb_wdata", wb_wdata, e_wdata);
    if (pend_chk) begin
      check("directed_wdata", wb_wdata, pend_exp);
      pend_chk = 1'b0;
    end
    rst_now = !rst_n;
    n_valid = m_valid; n_have = m_have; n_data = m_data; n_wbv = e_wb_valid;
    new_in = 1'b0;
    if (!rst_now) begin
      if (take) begin
        n_valid = ex_mem_valid; n_have = 1'b0; new_in = ex_mem_valid;
      end else if (m_valid && cur.is_load && dmem_rvalid && !m_have) begin
        n_have = 1'b1; n_data = dmem_rdata;
      end
      if (wb_allowin) n_wbv = offer;
    end
    @(posedge clk);
    #1;
    if (rst_now) begin
      m_valid = 1'b0; m_have = 1'b0; m_data = '0; e_wb_valid = 1'b0;
      e_pc = '0; e_inst = '0; e_req = 1'b0; e_waddr = '0; e_wdata = '0;
      resp_sent = 1'b1; stall_cnt = 0;
    end else begin
      if (acc) begin
        e_pc = cur.pc; e_inst = cur.inst; e_req = cur.req_rf; e_waddr = cur.waddr;
        e_wdata = cur.is_load ? align_ref(data, cur.a2, cur.mask) : cur.alu;
        if (cur.chk_en) begin pend_chk = 1'b1; pend_exp = cur.exp; end
      end
      m_valid = n_valid; m_have = n_have; m_data = n_data; e_wb_valid = n_wbv;
      if (new_in) begin
        cur = nxt;
        nxt = (dir_q.size() > 0) ? dir_q.pop_front() : rand_instr();
        resp_sent = !cur.is_load; wait_cnt = cur.delay;
      end
    end
    drive_inputs();
  endtask

  initial begin
    int guard;
    instr_t t;
    rst_n = 1'b0; hold_ex = 1'b0; pend_chk = 1'b0; pend_exp = '0; stall_cnt = 0;
    wait_cnt = 0; resp_sent = 1'b1;
    cur = rand_instr(); nxt = rand_instr();
    m_valid = 1'b0; m_have = 1'b0; m_data = '0; e_wb_valid = 1'b0;
    e_pc = '0; e_inst = '0; e_req = 1'b0; e_waddr = '0; e_wdata = '0;
    ex_mem_valid = 1'b0; wb_allowin = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    drive_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    repeat (300) tick();

    dir_q.push_back(mk(1'b0, 32'h0000_1234, 2'd0, 5'b00000, 32'h0, 0, 0, 32'h0000_1234));
    dir_q.push_back(mk(1'b1, 32'h0, 2'd3, 5'b00001, 32'h80FF_7F01, 1, 0, 32'hFFFF_FF80));
    dir_q.push_back(mk(1'b1, 32'h0, 2'd2, 5'b01000, 32'h80FF_7F01, 0, 0, 32'h0000_00FF));
    dir_q.push_back(mk(1'b1, 32'h0, 2'd2, 5'b00010, 32'h8001_7FFE, 2, 0, 32'hFFFF_8001));
    dir_q.push_back(mk(1'b1, 32'h0, 2'd0, 5'b10000, 32'h8001_7FFE, 0, 0, 32'h0000_7FFE));
    dir_q.push_back(mk(1'b1, 32'h0, 2'd1, 5'b00100, 32'h8001_7FFE, 0, 0, 32'h8001_7FFE));
    dir_q.push_back(mk(1'b1, 32'h0, 2'd0, 5'b00100, 32'h1357_9BDF, 3, 0, 32'h1357_9BDF));
    dir_q.push_back(mk(1'b1, 32'h0, 2'd0, 5'b00100, 32'hDEAD_BEEF, 1, 2, 32'hDEAD_BEEF));
    dir_q.push_back(mk(1'b1, 32'h0, 2'd3, 5'b00000, 32'hA5C3_0F81, 0, 0, 32'hA5C3_0F81));
    guard = 0;
    while ((dir_q.size() > 0 || pend_chk) && guard < 500) begin tick(); guard++; end
    repeat (20) tick();
    check("directed_drain", 32'(dir_q.size()), 32'd0);

    repeat (300) tick();

    t = rand_instr(); t.is_load = 1'b1; t.delay = 60; t.tag = 1;
    dir_q.push_back(t);
    guard = 0;
    while (!(m_valid && cur.tag == 1) && guard < 300) begin tick(); guard++; end
    check("reset_setup", 32'(m_valid && cur.tag == 1), 32'd1);
    repeat (3) tick();
    rst_n = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = $urandom;
    tick();
    rst_n = 1'b1; hold_ex = 1'b1;
    repeat (6) begin
      tick();
      check("post_reset_wb_valid", 32'(wb_valid), 32'd0);
      check("post_reset_wb_wdata", wb_wdata, 32'd0);
    end
    hold_ex = 1'b0;
    repeat (200) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
